// File: rtl/stream_pkg.sv
// Shared types and constants for the valid/ready stream source.
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_SUB = 32'd1;

    // Right-shifting Galois step: feedback bit is the LSB shifted out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/stream_lfsr.sv
// 32-bit Galois LFSR with synchronous load and advance; exposes the next state's low bits.
module stream_lfsr
    import stream_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [31:0]      i_seed,
    input  logic             i_adv,
    output logic [OUT_W-1:0] o_next
);

    logic [31:0] state_q;
    logic [31:0] state_nxt;

    assign state_nxt = lfsr_step(state_q);
    assign o_next    = state_nxt[OUT_W-1:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= '0;
        end else if (i_load) begin
            state_q <= i_seed;
        end else if (i_adv) begin
            state_q <= state_nxt;
        end
    end

endmodule

// File: rtl/stream_source.sv
// Valid/ready stream transmitter: sends a programmed number of patterned beats, then pulses done.
// Define STREAM_SRC_LFSR_EN to replace the incrementing pattern with a 32-bit Galois LFSR.
module stream_source
    import stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    parameter int GAP_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_count,
    input  logic [WIDTH-1:0] i_seed,
    input  logic [GAP_W-1:0] i_gap,
    output logic [WIDTH-1:0] o_data,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_beats
);

    state_t           state;
    logic [CNT_W-1:0] count_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic             xfer;
    logic             last_beat;
    logic [WIDTH-1:0] seed_data;
    logic [WIDTH-1:0] next_data;

    assign xfer      = (state == SEND) && o_vld && i_rdy;
    assign last_beat = (o_beats + 1'b1) == count_q;

`ifdef STREAM_SRC_LFSR_EN
    logic [31:0] lfsr_seed;

    // A zero seed would lock the LFSR, so it is substituted before load and before the first beat.
    assign lfsr_seed = (i_seed == '0) ? LFSR_SEED_SUB : 32'(i_seed);
    assign seed_data = lfsr_seed[WIDTH-1:0];

    stream_lfsr #(.OUT_W(WIDTH)) u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  ((state == IDLE) && i_start),
        .i_seed  (lfsr_seed),
        .i_adv   (xfer && !last_beat),
        .o_next  (next_data)
    );
`else
    assign seed_data = i_seed;
    assign next_data = o_data + 1'b1;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            count_q <= '0;
            gap_q   <= '0;
            gap_cnt <= '0;
            o_data  <= '0;
            o_vld   <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_beats <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        count_q <= i_count;
                        gap_q   <= i_gap;
                        o_beats <= '0;
                        o_busy  <= 1'b1;
                        if (i_count != '0) begin
                            o_data <= seed_data;
                            o_vld  <= 1'b1;
                            state  <= SEND;
                        end else begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                SEND: begin
                    if (xfer) begin
                        o_beats <= o_beats + 1'b1;
                        if (last_beat) begin
                            o_vld  <= 1'b0;
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            o_data <= next_data;
                            if (gap_q != '0) begin
                                o_vld   <= 1'b0;
                                gap_cnt <= gap_q;
                                state   <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    // gap_cnt counts the idle cycles still to show, including this one.
                    if (gap_cnt <= 1) begin
                        o_vld <= 1'b1;
                        state <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_source.sv
// Self-checking bench for stream_source: table of directed transfers, random transfers, async reset.
module tb_stream_source;

    localparam int W  = 8;
    localparam int CW = 16;
    localparam int GW = 4;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_start;
    logic [CW-1:0] i_count;
    logic [W-1:0]  i_seed;
    logic [GW-1:0] i_gap;
    logic [W-1:0]  o_data;
    logic          o_vld;
    logic          i_rdy;
    logic          o_busy;
    logic          o_done;
    logic [CW-1:0] o_beats;

    stream_source #(.WIDTH(W), .CNT_W(CW), .GAP_W(GW)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_count (i_count),
        .i_seed  (i_seed),
        .i_gap   (i_gap),
        .o_data  (o_data),
        .o_vld   (o_vld),
        .i_rdy   (i_rdy),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_beats (o_beats)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference pattern: beat k of a transfer seeded with 'seed'.
    function automatic logic [W-1:0] model_data(input logic [W-1:0] seed, input int k);
`ifdef STREAM_SRC_LFSR_EN
        logic [31:0] x;
        x = (seed == 0) ? 32'd1 : {24'd0, seed};
        for (int i = 0; i < k; i++)
            x = x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
        return x[W-1:0];
`else
        return W'((int'(seed) + k) % (1 << W));
`endif
    endfunction

    // Called at a falling edge. Sends one programmed transfer and checks every cycle of it.
    task automatic run_txn(input int cnt, input logic [W-1:0] seed, input int gap, input int pct,
                           input int hold, input int inj,
                           output logic [W-1:0] first, output logic [W-1:0] last);
        logic [W-1:0] exp_d;
        int stall;
        bit acc;
        first = '0;
        last  = '0;
        i_start = 1'b1;
        i_count = CW'(cnt);
        i_seed  = seed;
        i_gap   = GW'(gap);
        @(negedge i_clk);
        i_start = 1'b0;
        i_count = CW'($urandom);
        i_seed  = W'($urandom);
        i_gap   = GW'($urandom);
        if (cnt == 0) begin
            chk("zero_done", o_done, 1);
            chk("zero_vld",  o_vld,  0);
            chk("zero_busy", o_busy, 1);
            @(negedge i_clk);
            chk("zero_done_drop", o_done, 0);
            chk("zero_busy_drop", o_busy, 0);
            chk("zero_vld_after", o_vld,  0);
            return;
        end
        for (int k = 0; k < cnt; k++) begin
            exp_d = model_data(seed, k);
            chk("beat_vld",   o_vld,   1);
            chk("beat_data",  o_data,  exp_d);
            chk("beat_count", o_beats, k);
            chk("beat_busy",  o_busy,  1);
            if (k == 0) first = o_data;
            last  = o_data;
            stall = 0;
            do begin
                if (k == 0 && stall < hold) acc = 1'b0;
                else acc = (stall >= 40) || (int'($urandom_range(99)) < pct);
                i_rdy = acc;
                if (k == inj && stall == 0) begin
                    i_start = 1'b1;
                    i_count = '0;
                    i_seed  = W'($urandom);
                end
                @(negedge i_clk);
                i_start = 1'b0;
                if (!acc) begin
                    chk("stall_vld",  o_vld,  1);
                    chk("stall_data", o_data, exp_d);
                end
                stall++;
            end while (!acc);
            if (k < cnt - 1) begin
                repeat (gap) begin
                    chk("gap_vld", o_vld, 0);
                    i_rdy = 1'($urandom);
                    @(negedge i_clk);
                end
            end
        end
        chk("done_pulse", o_done,  1);
        chk("done_vld",   o_vld,   0);
        chk("done_beats", o_beats, cnt);
        i_rdy = 1'b0;
        @(negedge i_clk);
        chk("done_drop",  o_done,  0);
        chk("idle_busy",  o_busy,  0);
        chk("hold_beats", o_beats, cnt);
    endtask

    typedef struct {
        int          cnt;
        logic [W-1:0] seed;
        int          gap;
        int          pct;
        int          hold;
        int          inj;
        logic [W-1:0] exp_first;
        logic [W-1:0] exp_last;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] f, l;
        tbl[0] = '{4,  8'hFE, 0,  100, 0, -1, 8'hFE, 8'h01};
        tbl[1] = '{3,  8'h05, 2,  100, 0, -1, 8'h05, 8'h07};
        tbl[2] = '{2,  8'h10, 0,  100, 5, -1, 8'h10, 8'h11};
        tbl[3] = '{0,  8'h77, 3,  100, 0, -1, 8'h00, 8'h00};
        tbl[4] = '{10, 8'h40, 0,  100, 0,  3, 8'h40, 8'h49};
        tbl[5] = '{6,  8'hFD, 1,  50,  2, -1, 8'hFD, 8'h02};
        tbl[6] = '{2,  8'h80, 15, 100, 0, -1, 8'h80, 8'h81};

        i_reset = 1'b1;
        i_start = 1'b0;
        i_count = '0;
        i_seed  = '0;
        i_gap   = '0;
        i_rdy   = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_vld",   o_vld,   0);
        chk("rst_busy",  o_busy,  0);
        chk("rst_done",  o_done,  0);
        chk("rst_data",  o_data,  0);
        chk("rst_beats", o_beats, 0);
        i_reset = 1'b0;
        @(negedge i_clk);

        foreach (tbl[i]) begin
            run_txn(tbl[i].cnt, tbl[i].seed, tbl[i].gap, tbl[i].pct, tbl[i].hold, tbl[i].inj, f, l);
`ifndef STREAM_SRC_LFSR_EN
            if (tbl[i].cnt != 0) begin
                chk("tbl_first", f, tbl[i].exp_first);
                chk("tbl_last",  l, tbl[i].exp_last);
            end
`endif
            repeat (2) @(negedge i_clk);
        end

`ifdef STREAM_SRC_LFSR_EN
        run_txn(3, 8'h00, 0, 100, 0, -1, f, l);
        chk("lfsr_zero_seed_first", f, 8'h01);
        @(negedge i_clk);
`endif

        for (int r = 0; r < 8; r++) begin
            run_txn(int'($urandom_range(12, 1)), W'($urandom), int'($urandom_range(3)),
                    int'($urandom_range(100, 30)), 0, -1, f, l);
            repeat (int'($urandom_range(3))) @(negedge i_clk);
        end

        // Reset in the middle of a stalled beat after one beat was already accepted.
        i_start = 1'b1;
        i_count = 16'd5;
        i_seed  = 8'h33;
        i_gap   = '0;
        i_rdy   = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        i_rdy = 1'b0;
        chk("pre_rst_beats", o_beats, 1);
        @(negedge i_clk);
        chk("pre_rst_vld",  o_vld,  1);
        chk("pre_rst_data", o_data, 8'(model_data(8'h33, 1)));
        #2 i_reset = 1'b1;
        #1;
        chk("async_rst_vld",   o_vld,   0);
        chk("async_rst_busy",  o_busy,  0);
        chk("async_rst_beats", o_beats, 0);
        chk("async_rst_data",  o_data,  0);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        run_txn(1, 8'hAA, 0, 100, 0, -1, f, l);
        chk("post_rst_single", f, 8'hAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
